// File: rtl/dmem_pkg.sv
// Shared types for the data-space access controller: FSM states, decode regions
// and the byte-address decode used both at accept time and per byte phase.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_LO_W = 3'd2,
    ST_HI   = 3'd3,
    ST_HI_W = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RGN_REG  = 2'd0,
    RGN_IO   = 2'd1,
    RGN_SRAM = 2'd2,
    RGN_NONE = 2'd3
  } region_e;

  // a is 17 bits so that addr+1 of a word access never wraps back into range.
  function automatic region_e dmem_decode(
    input logic [16:0] a,
    input logic        io_only,
    input int unsigned nreg,
    input int unsigned nio,
    input int unsigned depth
  );
    int unsigned ai;
    ai = 32'(a);
    if (io_only) begin
      if (ai < nio) return RGN_IO;
      return RGN_NONE;
    end
    if (ai < nreg) return RGN_REG;
    if (ai < nreg + nio) return RGN_IO;
    if (ai < nreg + nio + depth) return RGN_SRAM;
    return RGN_NONE;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous byte RAM: one-cycle registered read, write-first.
module dmem_sram #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = 11
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wren_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    q_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wren_i) begin
      mem_q[addr_i] <= wdata_i;
      q_o           <= wdata_i;
    end else begin
      q_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-space access controller: decodes byte/word requests onto the GP register
// file, the I/O registers and an internal SRAM with a req/ack handshake.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned NREG       = 32,
  parameter int unsigned NIO        = 64,
  parameter int unsigned SRAM_DEPTH = 2048,
  parameter int unsigned SRAM_AW    = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [15:0]         addr,
  input  logic                we,
  input  logic                word,
  input  logic                io_only,
  input  logic [15:0]         wdata,
  input  logic [8*NREG-1:0]   register_bus,
  input  logic [8*NIO-1:0]    IO_bus,
  output logic [NREG-1:0]     reg_WE,
  output logic [NIO-1:0]      IO_WE,
  output logic [7:0]          wbyte,
  output logic [15:0]         rdata,
  output logic                ack,
  output logic                err,
  output logic                busy,
  output logic [2:0]          dbg_state_o
);

  // Handshake: req is sampled only while busy=0; an accepted access finishes
  // with a single-cycle ack (err qualifies it), and rdata holds until the next ack.

  localparam int unsigned SRAM_BASE = NREG + NIO;
  localparam int unsigned RW        = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned IW        = (NIO > 1) ? $clog2(NIO) : 1;

  state_e        state_q, state_d;
  logic [15:0]   addr_q, wdata_q;
  logic          we_q, word_q, io_q;
  logic [15:0]   rbuf_q, rbuf_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic          accept;
  logic [16:0]   acc_a_lo, acc_a_hi;
  region_e       acc_rgn_lo, acc_rgn_hi;
  logic          acc_oor;

  logic          hi_phase;
  logic [16:0]   cur_a;
  region_e       cur_rgn;
  logic [16:0]   cur_off;
  logic [RW-1:0] reg_idx;
  logic [IW-1:0] io_idx;
  logic [SRAM_AW-1:0] sram_addr;
  logic [7:0]    rd_byte, wr_byte, sram_q;
  logic          wr_cycle, sram_rd, sram_wren;
  logic          done;
  logic          unused_off;

  // Accept-time range check covers both bytes of a word access.
  assign accept     = (state_q == ST_IDLE) && req;
  assign acc_a_lo   = {1'b0, addr};
  assign acc_a_hi   = acc_a_lo + 17'd1;
  assign acc_rgn_lo = dmem_decode(acc_a_lo, io_only, NREG, NIO, SRAM_DEPTH);
  assign acc_rgn_hi = dmem_decode(acc_a_hi, io_only, NREG, NIO, SRAM_DEPTH);
  assign acc_oor    = (acc_rgn_lo == RGN_NONE) || (word && (acc_rgn_hi == RGN_NONE));

  assign hi_phase = (state_q == ST_HI) || (state_q == ST_HI_W);
  assign cur_a    = {1'b0, addr_q} + {16'd0, hi_phase};
  assign cur_rgn  = dmem_decode(cur_a, io_q, NREG, NIO, SRAM_DEPTH);

  always_comb begin
    cur_off = 17'd0;
    case (cur_rgn)
      RGN_REG:  cur_off = cur_a;
      RGN_IO:   cur_off = io_q ? cur_a : cur_a - 17'(NREG);
      RGN_SRAM: cur_off = cur_a - 17'(SRAM_BASE);
      default:  cur_off = 17'd0;
    endcase
  end

  assign reg_idx    = cur_off[RW-1:0];
  assign io_idx     = cur_off[IW-1:0];
  assign sram_addr  = cur_off[SRAM_AW-1:0];
  assign unused_off = ^cur_off;

  always_comb begin
    rd_byte = 8'h00;
    case (cur_rgn)
      RGN_REG: rd_byte = register_bus[{reg_idx, 3'b000} +: 8];
      RGN_IO:  rd_byte = IO_bus[{io_idx, 3'b000} +: 8];
      default: rd_byte = 8'h00;
    endcase
  end

  assign wr_byte  = hi_phase ? wdata_q[15:8] : wdata_q[7:0];
  assign wr_cycle = we_q && ((state_q == ST_LO) || (state_q == ST_HI));
  assign sram_rd  = !we_q && (cur_rgn == RGN_SRAM);

  // Strobes are decoded from the state register so an async reset drops them at once.
  always_comb begin
    reg_WE    = '0;
    IO_WE     = '0;
    wbyte     = 8'h00;
    sram_wren = 1'b0;
    if (wr_cycle) begin
      wbyte = wr_byte;
      case (cur_rgn)
        RGN_REG:  reg_WE[reg_idx] = 1'b1;
        RGN_IO:   IO_WE[io_idx]   = 1'b1;
        RGN_SRAM: sram_wren       = 1'b1;
        default:  ;
      endcase
    end
  end

  dmem_sram #(
    .DEPTH (SRAM_DEPTH),
    .AW    (SRAM_AW)
  ) u_sram (
    .clk_i   (clk),
    .addr_i  (sram_addr),
    .wren_i  (sram_wren),
    .wdata_i (wr_byte),
    .q_o     (sram_q)
  );

  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = acc_oor ? ST_ERR : ST_LO;
          rbuf_d  = 16'h0000;
        end
      end
      ST_LO: begin
        if (sram_rd) begin
          state_d = ST_LO_W;
        end else begin
          if (!we_q) rbuf_d[7:0] = rd_byte;
          if (word_q) state_d = ST_HI;
          else        done    = 1'b1;
        end
      end
      ST_LO_W: begin
        rbuf_d[7:0] = sram_q;
        if (word_q) state_d = ST_HI;
        else        done    = 1'b1;
      end
      ST_HI: begin
        if (sram_rd) begin
          state_d = ST_HI_W;
        end else begin
          if (!we_q) rbuf_d[15:8] = rd_byte;
          done = 1'b1;
        end
      end
      ST_HI_W: begin
        rbuf_d[15:8] = sram_q;
        done         = 1'b1;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
        err_d   = 1'b1;
        rdata_d = 16'h0000;
      end
      default: state_d = ST_IDLE;
    endcase
    // Completion loads the result register in the same edge as the last byte.
    if (done) begin
      state_d = ST_IDLE;
      ack_d   = 1'b1;
      rdata_d = we_q ? 16'h0000 : rbuf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      io_q    <= 1'b0;
      rbuf_q  <= 16'h0000;
      rdata_q <= 16'h0000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
        word_q  <= word;
        io_q    <= io_only;
      end
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Parametrised data-space access controller for the AVR core. It decodes a 16-bit data address into three windows in a fixed order: GP register file, I/O registers, internal SRAM.
- Adds a req/ack handshake, 8- and 16-bit accesses, and out-of-range error reporting.
- Issues write strobes only on writes, and waits correctly on synchronous-SRAM read latency.
- Sits between the execute/stack unit and the register file, I/O block and data SRAM.

Parameters:
NREG, 32, number of GP registers; register window is 0 .. NREG-1
NIO, 64, number of I/O registers; I/O window is NREG .. NREG+NIO-1
SRAM_DEPTH, 2048, SRAM bytes; SRAM window starts at SRAM_BASE = NREG+NIO
SRAM_AW, 11, SRAM address width; SRAM_DEPTH <= 2**SRAM_AW

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  1  access request; sampled only when busy=0
addr  in  16  byte address (I/O index when io_only=1)
we  in  1  1 = write, 0 = read
word  in  1  1 = 16-bit access: low byte at addr, high byte at addr+1
io_only  in  1  addr is a raw I/O index (IN/OUT addressing)
wdata  in  16  write data; [7:0] is the low byte, [15:8] the high byte
register_bus  in  8*NREG  all GP registers, reg i at [8i +: 8]
IO_bus  in  8*NIO  all I/O registers, reg i at [8i +: 8]
reg_WE  out  NREG  one-hot register write strobe
IO_WE  out  NIO  one-hot I/O write strobe
wbyte  out  8  byte to be written, valid while any strobe is high
rdata  out  16  read data; high byte is 0 for byte reads
ack  out  1  one-cycle completion pulse
err  out  1  qualifies ack: access rejected
busy  out  1  access in progress

Behaviour:
- Reset values: ack, err, busy, reg_WE, IO_WE, wbyte and rdata are all 0; FSM state is IDLE.
- Address decode, normal mode:
  - a < NREG: register a
  - a < SRAM_BASE: I/O register a-NREG
  - a < SRAM_BASE+SRAM_DEPTH: SRAM location a-SRAM_BASE
  - otherwise: out of range
- Address decode, io_only=1: a < NIO selects I/O register a; otherwise out of range.
- Range check at accept:
  - Both bytes of a word access are checked.
  - addr=0xFFFF with word=1 is out of range; there is no wrap-around.
  - A word access may straddle windows (e.g. 0x005F/0x0060); each byte is decoded independently.
- FSM states: IDLE, LO, LO_W, HI, HI_W, ERR.
  - IDLE --req--> ERR if the access is out of range, otherwise LO. Address, we, word and wdata are latched at accept.
  - LO and HI: drive the strobe or SRAM port for their byte.
  - LO_W and HI_W: entered only for SRAM reads, to capture SRAM q one cycle after the address is issued.
  - After LO/LO_W: go to HI if word=1, else back to IDLE.
  - After HI/HI_W or ERR: back to IDLE.
- Write strobe: exactly one bit of reg_WE or IO_WE is high for the single LO or HI cycle, with wbyte = the corresponding byte. SRAM wren is high only in that cycle.
- Reads: register/I/O bytes are captured at the end of LO/HI; SRAM bytes at the end of LO_W/HI_W.
- ack (registered): high for exactly one cycle as the FSM returns to IDLE, with rdata stable from that cycle until the next ack. busy is high from the cycle after accept up to, but not including, the ack cycle.
- Latency, accept edge to ack cycle:
  - byte register/I/O or any write: 2
  - byte SRAM read: 3
  - word: 1 + (1 per byte, +1 for each SRAM read byte); e.g. word SRAM read = 5, word register access = 3
  - error: 2
- On error: err=1 with ack, rdata=0, no strobe and no SRAM write.
- Back-to-back: a req high in the ack cycle is accepted (the FSM is already in IDLE).
- Reset mid-operation: the FSM returns immediately to IDLE and all strobes drop. A word write interrupted after LO keeps its low byte written and its high byte unwritten. No ack is issued.

Decomposition:
- Package dmem_pkg holds:
  - the state enum
  - region codes REG/IO/SRAM/NONE
  - a region-decode function
- Sub-module dmem_sram: single-port synchronous RAM, parameters DEPTH/AW, 1-cycle read latency, write-first.

Test Plan:
- Byte register read: register_bus reg5=0xA5, req at addr 0x0005 -> ack 2 cycles after accept, rdata=0x00A5, err=0, no strobes.
- Byte I/O write: addr 0x003F, wdata 0x005A -> IO_WE=1<<31 for one cycle, wbyte=0x5A, ack next cycle, reg_WE=0 throughout.
- SRAM word round trip: word write 0xBEEF to 0x0060, then word read of 0x0060 -> read ack 5 cycles after accept, rdata=0xBEEF. A byte read of 0x0061 then returns 0x00BE.
- Straddle: IO reg 63=0x12, SRAM[0]=0x34, word read at 0x005F -> rdata=0x3412, latency 4.
- Errors, each with no strobes or SRAM writes:
  - byte read at 0x0860 -> ack+err at latency 2, rdata=0
  - io_only with addr 0x0040 -> err
  - word at 0xFFFF -> err
- Reset mid-op: word write 0xBEEF to register 0x001E, rst_n low during HI -> reg 0x1E written, reg 0x1F not, busy=0, ack never asserted; the next req is accepted normally.
